// File: rtl/reg_file_sb.sv
// Multi-read-port integer register file with busy-bit scoreboard and post-reset self-clear.
// Optional same-cycle write-to-read bypass enabled by defining RF_BYPASS_EN.
module reg_file_sb #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_COUNT  = 32,
  parameter int unsigned REG_SIZE   = $clog2(REG_COUNT),
  parameter int unsigned NUM_RD     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD*REG_SIZE-1:0]   rdAddr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rdData,
  output logic [NUM_RD-1:0]            rdBusy,
  input  logic                         wrEn,
  input  logic [REG_SIZE-1:0]          wrAddr,
  input  logic [DATA_WIDTH-1:0]        wrData,
  input  logic                         busySet,
  input  logic [REG_SIZE-1:0]          busySetAddr,
  output logic                         ready
);

  localparam int unsigned DEPTH = 1 << REG_SIZE;

  // Entries that hold real state: nonzero and below REG_COUNT.
  function automatic logic [DEPTH-1:0] live_mask();
    logic [DEPTH-1:0] m;
    m = '0;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      m[i] = (i < REG_COUNT);
    end
    return m;
  endfunction

  localparam logic [DEPTH-1:0]    LIVE     = live_mask();
  localparam logic [REG_SIZE-1:0] CLR_LAST = REG_SIZE'(REG_COUNT - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t                state;
  state_t                state_next;
  logic [REG_SIZE-1:0]   clr_cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic [DEPTH-1:0]      busy_next;
  logic                  wr_fire;
  logic                  set_fire;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= CLEAR;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    if (state == CLEAR && clr_cnt == CLR_LAST) state_next = READY;
  end

  // Output logic
  always_comb begin
    ready = 1'b0;
    if (state == READY) ready = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)                 clr_cnt <= REG_SIZE'(1);
    else if (state == CLEAR) clr_cnt <= clr_cnt + REG_SIZE'(1);
  end

  assign wr_fire  = ready && wrEn && LIVE[wrAddr];
  assign set_fire = ready && busySet && LIVE[busySetAddr];

  // Storage: clear sweep has priority; writes only accepted once ready.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) mem[clr_cnt] <= '0;
      else if (wr_fire)   mem[wrAddr]  <= wrData;
    end
  end

  // Set is applied after clear so a new producer supersedes a retiring one.
  always_comb begin
    busy_next = busy;
    if (wr_fire)  busy_next[wrAddr]      = 1'b0;
    if (set_fire) busy_next[busySetAddr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_next;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [REG_SIZE-1:0] addr;
    logic                live;
    assign addr = rdAddr[i*REG_SIZE +: REG_SIZE];
    assign live = ready && LIVE[addr];
`ifdef RF_BYPASS_EN
    logic hit;
    assign hit = wr_fire && (wrAddr == addr);
    assign rdData[i*DATA_WIDTH +: DATA_WIDTH] = hit ? wrData : (live ? mem[addr] : '0);
    assign rdBusy[i] = live && !hit && busy[addr];
`else
    assign rdData[i*DATA_WIDTH +: DATA_WIDTH] = live ? mem[addr] : '0;
    assign rdBusy[i] = live && busy[addr];
`endif
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: driver queues expected outputs per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_reg_file_sb;

  localparam int unsigned DW = 32;
  localparam int unsigned RS = 5;
  localparam int unsigned NR = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR*RS-1:0] rdAddr;
  logic [NR*DW-1:0] rdData;
  logic [NR-1:0]    rdBusy;
  logic             wrEn;
  logic [RS-1:0]    wrAddr;
  logic [DW-1:0]    wrData;
  logic             busySet;
  logic [RS-1:0]    busySetAddr;
  logic             ready;

  reg_file_sb dut (
    .clk(clk), .rst(rst), .rdAddr(rdAddr), .rdData(rdData), .rdBusy(rdBusy),
    .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData), .busySet(busySet),
    .busySetAddr(busySetAddr), .ready(ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    int          port;
    logic [31:0] exp;
    int          test;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   test_id = 0;

  function automatic string kname(input int k);
    case (k)
      0:       return "rdData";
      1:       return "rdBusy";
      default: return "ready";
    endcase
  endfunction

  // Monitor: everything queued during a cycle is compared at its negedge.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      case (e.kind)
        0:       act = rdData[e.port*DW +: DW];
        1:       act = {31'b0, rdBusy[e.port]};
        default: act = {31'b0, ready};
      endcase
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL test%0d %s port%0d: got %h expected %h",
                 e.test, kname(e.kind), e.port, act, e.exp);
      end
    end
  end

  task automatic push(input int kind, input int port, input logic [31:0] v);
    exp_t e;
    e.kind = kind; e.port = port; e.exp = v; e.test = test_id;
    sbq.push_back(e);
  endtask

  task automatic exp_data(input int p, input logic [31:0] v);  push(0, p, v); endtask
  task automatic exp_busy(input int p, input logic v);         push(1, p, {31'b0, v}); endtask
  task automatic exp_ready(input logic v);                     push(2, 0, {31'b0, v}); endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rdAddr = {RS'(a1), RS'(a0)};
  endtask

  // Pulse rst for one edge, then expect exactly 31 not-ready windows.
  task automatic do_reset(input bit dirty);
    rst = 1'b1; wrEn = 1'b0; busySet = 1'b0;
    step();
    rst = 1'b0;
    for (int k = 0; k < 31; k++) begin
      if (dirty) begin
        wrEn = 1'b1; wrAddr = RS'(4); wrData = 32'hFF;
        busySet = 1'b1; busySetAddr = RS'(4);
        set_rd(4, 4);
        exp_data(0, 32'h0);
        exp_busy(0, 1'b0);
      end
      exp_ready(1'b0);
      step();
    end
    wrEn = 1'b0; busySet = 1'b0;
    exp_ready(1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; wrEn = 1'b0; wrAddr = '0; wrData = '0;
    busySet = 1'b0; busySetAddr = '0; rdAddr = '0;
    step();

    // 1: clear sequence and all-zero contents
    test_id = 1;
    do_reset(1'b0);
    for (int a = 0; a < 32; a++) begin
      set_rd(a, 31 - a);
      exp_data(0, 32'h0); exp_data(1, 32'h0);
      exp_busy(0, 1'b0);  exp_busy(1, 1'b0);
      step();
    end

    // 2: basic write and write to entry 0
    test_id = 2;
    wrEn = 1'b1; wrAddr = RS'(5); wrData = 32'hDEADBEEF; set_rd(0, 5);
`ifdef RF_BYPASS_EN
    exp_data(1, 32'hDEADBEEF);
`else
    exp_data(1, 32'h0);
`endif
    step();
    wrEn = 1'b0;
    exp_data(1, 32'hDEADBEEF);
    wrEn = 1'b1; wrAddr = RS'(0); wrData = 32'h1234; set_rd(0, 5);
    exp_data(0, 32'h0);
    step();
    wrEn = 1'b0;
    exp_data(0, 32'h0);
    exp_data(1, 32'hDEADBEEF);
    step();

    // 3: read of a register being written in the same cycle
    test_id = 3;
    wrEn = 1'b1; wrAddr = RS'(10); wrData = 32'h1;
    step();
    wrEn = 1'b1; wrAddr = RS'(10); wrData = 32'hA5A5A5A5; set_rd(10, 5);
`ifdef RF_BYPASS_EN
    exp_data(0, 32'hA5A5A5A5);
`else
    exp_data(0, 32'h1);
`endif
    exp_data(1, 32'hDEADBEEF);
    step();
    wrEn = 1'b0;
    exp_data(0, 32'hA5A5A5A5);
    step();

    // 4: scoreboard set / clear / simultaneous set+clear
    test_id = 4;
    busySet = 1'b1; busySetAddr = RS'(7); set_rd(7, 0);
    exp_busy(0, 1'b0);
    step();
    busySet = 1'b0;
    exp_busy(0, 1'b1); exp_busy(1, 1'b0);
    wrEn = 1'b1; wrAddr = RS'(7); wrData = 32'h77;
`ifdef RF_BYPASS_EN
    exp_busy(0, 1'b0);
`else
    exp_busy(0, 1'b1);
`endif
    step();
    wrEn = 1'b0;
    exp_busy(0, 1'b0);
    exp_data(0, 32'h77);
    wrEn = 1'b1; wrAddr = RS'(7); wrData = 32'h78;
    busySet = 1'b1; busySetAddr = RS'(7);
    step();
    wrEn = 1'b0; busySet = 1'b1; busySetAddr = RS'(0); set_rd(7, 0);
    exp_busy(0, 1'b1);
    exp_data(0, 32'h78);
    step();
    busySet = 1'b0;
    exp_busy(0, 1'b1);
    exp_busy(1, 1'b0);
    step();

    // 5: reset in the middle of the clear sweep
    test_id = 5;
    wrEn = 1'b1; wrAddr = RS'(3); wrData = 32'h55;
    step();
    wrEn = 1'b0; set_rd(3, 7);
    exp_data(0, 32'h55);
    exp_busy(1, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 9; k++) begin
      exp_ready(1'b0);
      step();
    end
    do_reset(1'b0);
    set_rd(3, 7);
    exp_data(0, 32'h0);
    exp_busy(1, 1'b0);
    exp_data(1, 32'h0);
    step();

    // 6: writes and issues during the clear sweep are ignored
    test_id = 6;
    do_reset(1'b1);
    set_rd(4, 4);
    exp_data(0, 32'h0); exp_data(1, 32'h0);
    exp_busy(0, 1'b0);  exp_busy(1, 1'b0);
    step();

    step();
    step();
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
